// File: rtl/modmul_interleaved_if.sv
// modmul_interleaved_if: request/result bundle for the interleaved modular multiplier.
//   master: drives start, X, Y, M; receives Q, done, busy, err
//   slave : the multiplier side of the same signals
//   start - request pulse/level, sampled only while busy is low
//   X, Y  - operands (expected < M), M - modulus
//   Q     - result, valid from done until the next accepted start
//   done  - one-cycle completion pulse, busy - job in flight, err - range error
interface modmul_interleaved_if #(
  parameter int unsigned WIDTH = 256
);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] M;
  logic [WIDTH-1:0] Q;
  logic             done;
  logic             busy;
  logic             err;

  modport master (
    output start, X, Y, M,
    input  Q, done, busy, err
  );

  modport slave (
    input  start, X, Y, M,
    output Q, done, busy, err
  );
endinterface

// File: rtl/modmul_interleaved.sv
// modmul_interleaved: iterative Q = (X * Y) mod M, radix-2 interleaved (Blakley), MSB-first
// over X, one operand bit per clock. Fixed latency of WIDTH+1 cycles from acceptance.
//   clock - rising-edge clock
//   rst   - synchronous active-high reset
//   i_bus - modmul_interleaved_if.slave (start/X/Y/M in, Q/done/busy/err out)
// Optional build macro MODMUL_RANGE_CHECK_EN: flags X>=M, Y>=M or M<2 on err (with Q=0) at done.
// Without it err is tied low and only the degenerate-modulus (M<2) case forces Q=0.
module modmul_interleaved #(
  parameter  int unsigned WIDTH = 256,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input logic                 clock,
  input logic                 rst,
  modmul_interleaved_if.slave i_bus
);

  typedef enum logic [1:0] {StIdle, StIter, StFinish} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_x, r_y, r_m, r_q;
  logic [WIDTH+1:0] r_r, w_t, w_r_next, w_m1, w_m2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done, r_busy, r_degen;
  logic             w_accept, w_degen;

  // Result is forced to zero for these jobs instead of trusting the datapath.
`ifdef MODMUL_RANGE_CHECK_EN
  logic r_err;
  assign w_degen = ~|i_bus.M[WIDTH-1:1] | (i_bus.X >= i_bus.M) | (i_bus.Y >= i_bus.M);
`else
  assign w_degen = ~|i_bus.M[WIDTH-1:1];
`endif

  // With R < M the partial sum is below 3M, so at most two subtractions of M are needed.
  assign w_m1 = {2'b00, r_m};
  assign w_m2 = {1'b0, r_m, 1'b0};
  assign w_t  = (r_r << 1) + (r_x[r_cnt] ? {2'b00, r_y} : '0);

  always_comb begin
    w_r_next = w_t;
    if (w_t >= w_m2) begin
      w_r_next = w_t - w_m2;
    end else if (w_t >= w_m1) begin
      w_r_next = w_t - w_m1;
    end
  end

  // busy stays high through the done cycle, which blocks a start coincident with done.
  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_bus.start && !r_busy) begin
          w_accept  = 1'b1;
          w_state_d = StIter;
        end
      end
      StIter: begin
        if (r_cnt == '0) begin
          w_state_d = StFinish;
        end
      end
      StFinish: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= StIdle;
      r_x     <= '0;
      r_y     <= '0;
      r_m     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_degen <= 1'b0;
`ifdef MODMUL_RANGE_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_done  <= 1'b0;
      if (r_done) begin
        r_busy <= 1'b0;
      end
      if (w_accept) begin
        r_x     <= i_bus.X;
        r_y     <= i_bus.Y;
        r_m     <= i_bus.M;
        r_r     <= '0;
        r_cnt   <= CNT_W'(WIDTH - 1);
        r_busy  <= 1'b1;
        r_degen <= w_degen;
`ifdef MODMUL_RANGE_CHECK_EN
        r_err   <= 1'b0;
`endif
      end
      if (r_state == StIter) begin
        r_r   <= w_r_next;
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (r_state == StFinish) begin
        r_q    <= r_degen ? '0 : r_r[WIDTH-1:0];
        r_done <= 1'b1;
`ifdef MODMUL_RANGE_CHECK_EN
        r_err  <= r_degen;
`endif
      end
    end
  end

  assign i_bus.Q    = r_q;
  assign i_bus.done = r_done;
  assign i_bus.busy = r_busy;
`ifdef MODMUL_RANGE_CHECK_EN
  assign i_bus.err  = r_err;
`else
  assign i_bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_modmul_interleaved.sv
// Bench for modmul_interleaved: an 8-bit instance tracked cycle-by-cycle by a job-level model,
// plus a 256-bit instance exercised with directed/random jobs against wide arithmetic.
module tb_modmul_interleaved;
  localparam int unsigned W  = 8;
  localparam int unsigned WB = 256;
`ifdef MODMUL_RANGE_CHECK_EN
  localparam bit RangeEn = 1'b1;
`else
  localparam bit RangeEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  modmul_interleaved_if #(.WIDTH(W))  bus8 ();
  modmul_interleaved_if #(.WIDTH(WB)) bus256 ();

  modmul_interleaved #(.WIDTH(W)) u_dut8 (
    .clock (clock),
    .rst   (rst),
    .i_bus (bus8)
  );

  modmul_interleaved #(.WIDTH(WB)) u_dut256 (
    .clock (clock),
    .rst   (rst),
    .i_bus (bus256)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WB-1:0] ref_mod(input logic [WB-1:0] x, input logic [WB-1:0] y,
                                            input logic [WB-1:0] m);
    logic [2*WB-1:0] p;
    if (m < 2) return '0;
    p = (2*WB)'(x) * (2*WB)'(y);
    return WB'(p % (2*WB)'(m));
  endfunction

  // Job-level model of the 8-bit instance.
  int         cyc = 0;
  bit         m_active = 1'b0;
  int         m_acc = 0;
  logic [W-1:0] m_q = '0, j_q = '0;
  bit         m_qknown = 1'b1, j_known = 1'b1;
  bit         m_err = 1'b0, j_err = 1'b0;
  bit         chk_en = 1'b0;

  always @(posedge clock) begin : model
    logic [W-1:0] x, y, m;
    bit bad;
    cyc++;
    if (rst) begin
      m_active = 1'b0;
      m_q      = '0;
      m_qknown = 1'b1;
      m_err    = 1'b0;
    end else begin
      if (m_active && cyc == m_acc + W + 1) begin
        m_q      = j_q;
        m_qknown = j_known;
        m_err    = j_err;
      end
      if (!m_active && bus8.start) begin
        x = bus8.X; y = bus8.Y; m = bus8.M;
        bad = (x >= m) || (y >= m);
        if (RangeEn && (bad || m < 2)) begin
          j_q = '0; j_known = 1'b1; j_err = 1'b1;
        end else if (m < 2) begin
          j_q = '0; j_known = 1'b1; j_err = 1'b0;
        end else begin
          j_q = W'(ref_mod(WB'(x), WB'(y), WB'(m))); j_known = !bad; j_err = 1'b0;
        end
        m_err    = 1'b0;
        m_active = 1'b1;
        m_acc    = cyc;
      end else if (m_active && cyc == m_acc + W + 2) begin
        m_active = 1'b0;
      end
    end
  end

  always @(negedge clock) begin : compare
    bit exp_done;
    if (chk_en) begin
      exp_done = m_active && (cyc == m_acc + W + 1);
      check("done8", WB'(bus8.done), WB'(exp_done));
      check("busy8", WB'(bus8.busy), WB'(m_active));
      check("err8", WB'(bus8.err), WB'(m_err));
      if (m_qknown) check("q8", WB'(bus8.Q), WB'(m_q));
    end
  end

  task automatic job8(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] m,
                      input int exp_q, input string name);
    int n = 0;
    bit seen = 1'b0;
    bus8.X = x; bus8.Y = y; bus8.M = m; bus8.start = 1'b1;
    @(posedge clock); #1;
    bus8.start = 1'b0;
    while (!seen && n < 4 * W) begin
      @(posedge clock); #1;
      n++;
      if (bus8.done) seen = 1'b1;
    end
    check({name, " latency"}, WB'(n), WB'(W + 1));
    if (exp_q >= 0) check({name, " q"}, WB'(bus8.Q), WB'(exp_q));
    @(posedge clock); #1;
  endtask

  task automatic job256(input logic [WB-1:0] x, input logic [WB-1:0] y, input logic [WB-1:0] m,
                        input string name);
    int n = 0;
    bit seen = 1'b0;
    bus256.X = x; bus256.Y = y; bus256.M = m; bus256.start = 1'b1;
    @(posedge clock); #1;
    bus256.start = 1'b0;
    while (!seen && n < WB + 40) begin
      @(posedge clock); #1;
      n++;
      if (bus256.done) seen = 1'b1;
    end
    check({name, " latency"}, WB'(n), WB'(WB + 1));
    check({name, " q"}, bus256.Q, ref_mod(x, y, m));
    check({name, " err"}, WB'(bus256.err), '0);
    @(posedge clock); #1;
  endtask

  function automatic logic [WB-1:0] rand_wide();
    logic [WB-1:0] v = '0;
    for (int i = 0; i < WB / 32; i++) v = (v << 32) | WB'($urandom);
    return v;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [WB-1:0] mw, xw, yw;
    logic [W-1:0]  x, y, m;
    int dcount;
    rst = 1'b1;
    bus8.start = 1'b0;   bus8.X = '0;   bus8.Y = '0;   bus8.M = '0;
    bus256.start = 1'b0; bus256.X = '0; bus256.Y = '0; bus256.M = '0;

    // Model pins against hand-computed values.
    check("model 7*9%11", ref_mod(7, 9, 11), 8);
    check("model 254*254%255", ref_mod(254, 254, 255), 1);
    check("model 2*3%11", ref_mod(2, 3, 11), 6);
    check("model m=1", ref_mod(0, 0, 1), 0);

    repeat (3) @(posedge clock);
    #1;
    rst = 1'b0;
    check("reset q", WB'(bus8.Q), '0);
    check("reset done", WB'(bus8.done), '0);
    check("reset busy", WB'(bus8.busy), '0);
    check("reset err", WB'(bus8.err), '0);
    chk_en = 1'b1;

    job8(7, 9, 11, 8, "7*9%11");
    job8(254, 254, 255, 1, "254*254%255");
    job8(0, 200, 255, 0, "0*200%255");
    job8(5, 6, 0, 0, "m=0");
    job8(0, 0, 1, 0, "m=1");

    // Start held high: one job in flight at a time, second accepted only after done.
    bus8.X = 3; bus8.Y = 5; bus8.M = 7; bus8.start = 1'b1;
    dcount = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (bus8.done) dcount++;
    end
    bus8.start = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
      if (bus8.done) dcount++;
    end
    check("held start done pulses", WB'(dcount), 2);
    check("held start q", WB'(bus8.Q), 1);

    // Reset in the middle of a job aborts it without a done pulse.
    bus8.X = 7; bus8.Y = 9; bus8.M = 11; bus8.start = 1'b1;
    @(posedge clock); #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    rst = 1'b1;
    @(posedge clock); #1;
    rst = 1'b0;
    check("abort q", WB'(bus8.Q), '0);
    check("abort busy", WB'(bus8.busy), '0);
    dcount = 0;
    repeat (W + 5) begin
      @(posedge clock); #1;
      if (bus8.done) dcount++;
    end
    check("abort no done", WB'(dcount), '0);
    job8(2, 3, 5, 1, "after abort 2*3%5");

    // Out-of-range operand, then a normal job clearing err.
    job8(12, 3, 11, RangeEn ? 0 : -1, "x>=m");
    check("x>=m err", WB'(bus8.err), WB'(RangeEn));
    job8(2, 3, 11, 6, "2*3%11");
    check("2*3%11 err", WB'(bus8.err), '0);

    // Randomised jobs, including occasional degenerate/out-of-range ones.
    for (int i = 0; i < 40; i++) begin
      m = W'($urandom_range(2, 255));
      x = W'($urandom_range(0, int'(m) - 1));
      y = W'($urandom_range(0, int'(m) - 1));
      if (i % 10 == 3) m = W'($urandom_range(0, 1));
      if (i % 10 == 7) x = W'($urandom_range(int'(m), 255));
      job8(x, y, m, -1, "rand8");
    end

    // Wide instance.
    mw = '1;
    xw = mw - 1;
    check("model (m-1)^2", ref_mod(xw, xw, mw), 1);
    job256(xw, xw, mw, "w256 (2^256-2)^2");
    mw = (WB'(1) << 255) - 19;
    for (int i = 0; i < 3; i++) begin
      xw = rand_wide() % mw;
      yw = rand_wide() % mw;
      job256(xw, yw, mw, "w256 p25519");
    end

    repeat (3) @(posedge clock);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
